// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the five-stage RISC-V pipeline: Execute operand
// forwarding, per-stage stall/flush, multi-cycle mul/div sequencing and memory timeout.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES   = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_Rs1D,
    input  logic [4:0] i_Rs2D,
    input  logic [4:0] i_Rs1E,
    input  logic [4:0] i_Rs2E,
    input  logic [4:0] i_RdE,
    input  logic [4:0] i_RdM,
    input  logic [4:0] i_RdW,
    input  logic       i_RegWriteM,
    input  logic       i_RegWriteW,
    input  logic [1:0] i_ResultSrcE,
    input  logic       i_PCSrcE,
    input  logic       i_MulDivStartE,
    input  logic       i_MemReqM,
    input  logic       i_MemReadyM,
    output logic [1:0] o_ForwardAE,
    output logic [1:0] o_ForwardBE,
    output logic       o_StallF,
    output logic       o_StallD,
    output logic       o_StallE,
    output logic       o_StallM,
    output logic       o_FlushD,
    output logic       o_FlushE,
    output logic       o_FlushM,
    output logic       o_FlushW,
    output logic       o_MulDivBusy,
    output logic       o_MemErr
);

    localparam int CW = $clog2(MD_CYCLES);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] MD_LOAD   = CW'(MD_CYCLES - 2);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    mdState_t        r_state;
    logic [CW-1:0]   r_cnt;
    logic [WW-1:0]   r_wcnt;
    logic            r_memErr;

    logic w_lwStall;
    logic w_memStall;
    logic w_mdStall;

    // M-stage result is newer than W-stage, so it wins when both match.
    always_comb begin
        o_ForwardAE = 2'b00;
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs1E))
            o_ForwardAE = 2'b10;
        else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs1E))
            o_ForwardAE = 2'b01;
    end

    always_comb begin
        o_ForwardBE = 2'b00;
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs2E))
            o_ForwardBE = 2'b10;
        else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs2E))
            o_ForwardBE = 2'b01;
    end

    assign w_lwStall  = (i_ResultSrcE == 2'b01) && (i_RdE != 5'd0) &&
                        ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    assign w_memStall = i_MemReqM && !i_MemReadyM;

    // The last busy cycle (cnt == 0) releases the stall so the op can advance.
    always_comb begin
        w_mdStall = 1'b0;
        case (r_state)
            IDLE:    w_mdStall = i_MulDivStartE;
            MD_BUSY: w_mdStall = (r_cnt != '0);
            default: w_mdStall = 1'b0;
        endcase
    end

    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        o_FlushM = 1'b0;
        o_FlushW = 1'b0;
        if (w_memStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_StallM = 1'b1;
            o_FlushW = 1'b1;
        end else if (w_mdStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_StallE = 1'b1;
            o_FlushM = 1'b1;
        end else if (i_PCSrcE) begin
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
        end else if (w_lwStall) begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
        end
    end

    // Whole pipeline freezes on a memory wait, so the mul/div sequence freezes too.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!w_memStall) begin
            case (r_state)
                IDLE: begin
                    if (i_MulDivStartE) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                    else
                        r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wcnt   <= '0;
            r_memErr <= 1'b0;
        end else begin
            if (!w_memStall)
                r_wcnt <= '0;
            else if (r_wcnt != WAIT_MAX)
                r_wcnt <= r_wcnt + 1'b1;
            if (w_memStall && (r_wcnt == WAIT_LAST))
                r_memErr <= 1'b1;
        end
    end

    assign o_MulDivBusy = (r_state == MD_BUSY);
    assign o_MemErr     = r_memErr;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: forwarding, load-use,
// mul/div sequencing with and without memory waits, redirect priority and timeout.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MulDivStartE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushM, FlushW;
    logic       MulDivBusy, MemErr;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .MEM_TIMEOUT(16)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_Rs1D(Rs1D), .i_Rs2D(Rs2D), .i_Rs1E(Rs1E), .i_Rs2E(Rs2E),
        .i_RdE(RdE), .i_RdM(RdM), .i_RdW(RdW),
        .i_RegWriteM(RegWriteM), .i_RegWriteW(RegWriteW),
        .i_ResultSrcE(ResultSrcE), .i_PCSrcE(PCSrcE),
        .i_MulDivStartE(MulDivStartE), .i_MemReqM(MemReqM), .i_MemReadyM(MemReadyM),
        .o_ForwardAE(ForwardAE), .o_ForwardBE(ForwardBE),
        .o_StallF(StallF), .o_StallD(StallD), .o_StallE(StallE), .o_StallM(StallM),
        .o_FlushD(FlushD), .o_FlushE(FlushE), .o_FlushM(FlushM), .o_FlushW(FlushW),
        .o_MulDivBusy(MulDivBusy), .o_MemErr(MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 2'b00; PCSrcE = 0;
        MulDivStartE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic checkStalls(input string tag, input logic [7:0] expected);
        checkOutput(tag, {24'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW},
                    {24'd0, expected});
    endtask

    initial begin
        applyStimulus();
        reset = 1'b1;
        #12;
        checkStalls("reset_stall_flush", 8'b0000_0000);
        checkOutput("reset_fwdA", ForwardAE, 0);
        checkOutput("reset_fwdB", ForwardBE, 0);
        checkOutput("reset_busy", MulDivBusy, 0);
        checkOutput("reset_memerr", MemErr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Forwarding priority
        @(negedge clk);
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        #1 checkOutput("fwdA_M", ForwardAE, 2'b10);
        checkOutput("fwdB_none", ForwardBE, 2'b00);
        @(negedge clk);
        RegWriteM = 0;
        #1 checkOutput("fwdA_W", ForwardAE, 2'b01);
        @(negedge clk);
        RdM = 0; RdW = 0;
        #1 checkOutput("fwdA_x0", ForwardAE, 2'b00);
        @(negedge clk);
        RegWriteM = 1; RdM = 9; Rs2E = 9; RdW = 9; Rs1E = 3;
        #1 checkOutput("fwdB_M", ForwardBE, 2'b10);
        checkOutput("fwdA_nomatch", ForwardAE, 2'b00);
        @(negedge clk);
        RegWriteM = 0;
        #1 checkOutput("fwdB_W", ForwardBE, 2'b01);
        applyStimulus();

        // Load-use
        @(negedge clk);
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1 checkStalls("loaduse", 8'b1100_0100);
        @(negedge clk);
        RdE = 0; Rs2D = 0;
        #1 checkStalls("loaduse_x0", 8'b0000_0000);
        @(negedge clk);
        RdE = 7; Rs1D = 7; ResultSrcE = 2'b00;
        #1 checkStalls("notload", 8'b0000_0000);
        @(negedge clk);
        ResultSrcE = 2'b01; PCSrcE = 1;
        #1 checkStalls("redirect_over_lw", 8'b0000_1100);
        applyStimulus();

        // Undisturbed mul/div: stall cycles 0-2, busy cycles 1-3
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            MulDivStartE = 1;
            #1 checkStalls($sformatf("md_stall_c%0d", c), (c < 3) ? 8'b1110_0010 : 8'b0000_0000);
            checkOutput($sformatf("md_busy_c%0d", c), MulDivBusy, (c >= 1) ? 1 : 0);
        end
        @(negedge clk);
        MulDivStartE = 0;
        #1 checkOutput("md_idle_c4", MulDivBusy, 0);
        checkStalls("md_nostall_c4", 8'b0000_0000);

        // Mul/div with a 2-cycle memory wait on cycles 1-2 (redirect on cycle 1 is suppressed)
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            MulDivStartE = 1;
            MemReqM   = (c == 1 || c == 2);
            MemReadyM = 0;
            PCSrcE    = (c == 1);
            #1;
            if (c == 1 || c == 2)
                checkStalls($sformatf("mdmem_stall_c%0d", c), 8'b1111_0001);
            else if (c == 5)
                checkStalls($sformatf("mdmem_stall_c%0d", c), 8'b0000_0000);
            else
                checkStalls($sformatf("mdmem_stall_c%0d", c), 8'b1110_0010);
            checkOutput($sformatf("mdmem_busy_c%0d", c), MulDivBusy, (c >= 1) ? 1 : 0);
        end
        @(negedge clk);
        applyStimulus();
        #1 checkOutput("mdmem_idle_c6", MulDivBusy, 0);

        // Redirect without stall
        @(negedge clk);
        PCSrcE = 1;
        #1 checkStalls("redirect", 8'b0000_1100);
        applyStimulus();

        // Memory timeout: error after the 16th consecutive wait cycle
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            MemReqM = 1; MemReadyM = 0;
            #1 checkOutput($sformatf("tmo_noerr_c%0d", c), MemErr, 0);
        end
        @(negedge clk);
        MemReadyM = 1;
        #1 checkOutput("tmo_err", MemErr, 1);
        checkOutput("tmo_stallM_off", StallM, 0);
        @(negedge clk);
        applyStimulus();
        #1 checkOutput("tmo_sticky", MemErr, 1);
        #1 reset = 1'b1;
        #1 checkOutput("tmo_async_clear", MemErr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Short wait below the limit must not set the error
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            MemReqM = 1; MemReadyM = 0;
        end
        @(negedge clk);
        applyStimulus();
        #1 checkOutput("tmo_15_noerr", MemErr, 0);

        // Reset in the middle of a mul/div aborts it
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            MulDivStartE = 1;
        end
        #1 checkOutput("abort_busy_before", MulDivBusy, 1);
        #1 reset = 1'b1;
        #1 checkOutput("abort_busy_after", MulDivBusy, 0);
        @(negedge clk);
        applyStimulus();
        reset = 1'b0;
        #1 checkStalls("abort_nostall", 8'b0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage RISC-V pipeline. It drives operand forwarding for Execute and generates per-stage stall and flush controls. FlushE drives the `clear` input of the Decode-to-Execute control pipeline register. Sequential state sequences multi-cycle mul/div operations held in Execute and tracks data-memory wait states, raising a sticky timeout error.

## Interface
- MD_CYCLES, 4: total cycles a mul/div op occupies Execute; must be >= 2
- MEM_TIMEOUT, 16: consecutive memory-wait cycles tolerated before MemErr; must be >= 1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Rs1D, Rs2D  in  5 each  source registers in Decode
- Rs1E, Rs2E, RdE  in  5 each  sources and destination in Execute
- RdM, RdW  in  5 each  destinations in Memory and Writeback
- RegWriteM, RegWriteW  in  1 each  register-write enables of M and W
- ResultSrcE  in  2  result select in E; 2'b01 marks a load
- PCSrcE  in  1  taken branch or jump resolved in E
- MulDivStartE  in  1  E holds a mul/div op
- MemReqM, MemReadyM  in  1 each  data-memory request and ready in M
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 W result, 10 M ALU result
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / stage register
- FlushD, FlushE, FlushM, FlushW  out  1 each  bubble into the stage register
- MulDivBusy  out  1  FSM in MD_BUSY
- MemErr  out  1  sticky memory timeout flag

## Operation
- Forwarding (combinational, per operand X in {A, B}, using Rs1E for A and Rs2E for B):
  - 10 if RegWriteM, RdM != 0 and RdM == RsXE.
  - Otherwise 01 if RegWriteW, RdW != 0 and RdW == RsXE.
  - Otherwise 00. M has priority over W.
- lwStall = (ResultSrcE == 01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- memStall = MemReqM && !MemReadyM.
- mdStall:
  - In IDLE: MulDivStartE.
  - In MD_BUSY: cnt != 0.
  - Otherwise 0.
- MD FSM has two states, IDLE and MD_BUSY, with a counter cnt of width $clog2(MD_CYCLES).
  - IDLE && MulDivStartE && !memStall: go to MD_BUSY, cnt <= MD_CYCLES-2.
  - MD_BUSY && !memStall: if cnt != 0, cnt <= cnt-1; if cnt == 0, go to IDLE.
  - While memStall, state and cnt hold.
- Priority, highest first:
  1. memStall: StallF, StallD, StallE, StallM = 1; FlushW = 1; FlushD, FlushE, FlushM = 0.
  2. mdStall: StallF, StallD, StallE = 1; FlushM = 1; FlushD, FlushE = 0.
  3. PCSrcE: FlushD = 1, FlushE = 1; no stalls, so the redirect wins over lwStall.
  4. lwStall: StallF = 1, StallD = 1, FlushE = 1.
- Memory timeout:
  - wcnt (width $clog2(MEM_TIMEOUT+1)) increments while memStall, saturating at MEM_TIMEOUT.
  - wcnt clears when memStall = 0.
  - MemErr <= 1 when memStall && wcnt == MEM_TIMEOUT-1; it stays 1 until reset.
- MulDivBusy = (state == MD_BUSY).

## Timing
- Reset values:
  - State: IDLE, cnt = 0, wcnt = 0, MemErr = 0.
  - With all inputs 0, every output is 0.
  - Reset mid-mul/div or mid-wait aborts immediately; MemErr is cleared.
- All stall, flush and forward outputs are combinational from inputs and state; zero-cycle latency.
- A mul/div op stays in E for exactly MD_CYCLES cycles. Stall is high for the first MD_CYCLES-1 of them and low on the last, when the op advances.
- The FSM never re-triggers on the same op: in the final cycle, MD_BUSY with cnt == 0 ignores MulDivStartE.
- Back-to-back mul/div: a new op in E the cycle after completion starts a fresh sequence.
- Load-use costs one bubble: lwStall is high for one cycle, then the load moves to M and forwarding supplies the value from W.

## Test plan
- Forwarding: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Then RegWriteM = 0 -> ForwardAE = 01. Then RdM = RdW = 0 -> ForwardAE = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 for one cycle -> StallF = StallD = FlushE = 1 that cycle. Same with RdE = 0 -> all three stay 0.
- MD_CYCLES = 4, MulDivStartE held 4 cycles:
  - StallE = 1 on cycles 0-2 and 0 on cycle 3.
  - FlushM = 1 on cycles 0-2.
  - MulDivBusy = 1 on cycles 1-3.
  - FSM returns to IDLE on cycle 4.
- Memory wait during mul/div (MemReqM = 1, MemReadyM = 0) for 2 cycles on cycle 1:
  - All four stalls and FlushW are high.
  - cnt holds at 2.
  - The mul/div completes 2 cycles later than in the undisturbed case.
- Timeout, MEM_TIMEOUT = 16: MemReadyM = 0 for 16 cycles -> MemErr rises after the 16th stall cycle and stays 1 after ready returns. Asserting reset clears it asynchronously.
- PCSrcE = 1 together with memStall -> FlushD = FlushE = 0. The same PCSrcE with no stall -> FlushD = FlushE = 1.
